mult8x8_seq_ctrl: RTL and testbench



---
 rtl/mult8x8_seq_ctrl.sv | 110 +++++++++++
 tb/tb_mult8x8_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult8x8_seq_ctrl.sv
// rtl/mult8x8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over one shared 4x4 carry-save array multiplier
module carry_save_array_multiplier_19BEE0032 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s1, c1, s2, c2, s3, c3;

    assign pp0 = {4'b0000, a & {4{b[0]}}};
    assign pp1 = {3'b000, a & {4{b[1]}}, 1'b0};
    assign pp2 = {2'b00, a & {4{b[2]}}, 2'b00};
    assign pp3 = {1'b0, a & {4{b[3]}}, 3'b000};

    // Rows are reduced in sum/carry form; a single ripple add resolves the last pair.
    assign s1 = pp0 ^ pp1;
    assign c1 = {pp0[6:0] & pp1[6:0], 1'b0};
    assign s2 = s1 ^ c1 ^ pp2;
    assign c2 = {(s1[6:0] & c1[6:0]) | (s1[6:0] & pp2[6:0]) | (c1[6:0] & pp2[6:0]), 1'b0};
    assign s3 = s2 ^ c2 ^ pp3;
    assign c3 = {(s2[6:0] & c2[6:0]) | (s2[6:0] & pp3[6:0]) | (c2[6:0] & pp3[6:0]), 1'b0};
    assign p  = s3 + c3;
endmodule

module mult8x8_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [7:0]  op_a, op_b;
    logic [15:0] acc;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic [15:0] addend;

    // step[0] picks the high nibble of a, step[1] the high nibble of b.
    assign mul_a = step[0] ? op_a[7:4] : op_a[3:0];
    assign mul_b = step[1] ? op_b[7:4] : op_b[3:0];

    carry_save_array_multiplier_19BEE0032 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        addend = 16'h0000;
        case (step)
            2'd0:    addend = {8'h00, mul_p};
            2'd1:    addend = {4'h0, mul_p, 4'h0};
            2'd2:    addend = {4'h0, mul_p, 4'h0};
            default: addend = {mul_p, 8'h00};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= 2'd0;
            acc   <= 16'h0000;
            op_a  <= 8'h00;
            op_b  <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= in_a;
                        op_b <= in_b;
                        acc  <= 16'h0000;
                        step <= 2'd0;
                    end
                end
                MUL: begin
                    acc  <= acc + addend;
                    step <= step + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL;
            MUL:     if (step == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_p     = out_valid ? acc : 16'h0000;
endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// tb/tb_mult8x8_seq_ctrl.sv - self-checking bench for mult8x8_seq_ctrl
module tb_mult8x8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_p;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mult8x8_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted pair keeps the unit busy for four edges, then the
    // product is offered until consumed.
    int          m_mode = 0;   // 0 idle, 1 busy, 2 offering result
    int          m_cnt = 0;
    logic [15:0] m_prod = 16'h0;
    bit          m_live = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode = 0; m_cnt = 0; m_prod = 16'h0; m_live = 1;
            end else if (m_live) begin
                case (m_mode)
                    0: if (in_valid) begin
                        m_mode = 1; m_cnt = 4; m_prod = 16'(in_a) * 16'(in_b);
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) m_mode = 2;
                    end
                    default: if (out_ready) m_mode = 0;
                endcase
            end
            #2;
            if (m_live) begin
                check("model_in_ready", 32'(in_ready), 32'(m_mode == 0 && !rst));
                check("model_out_valid", 32'(out_valid), 32'(m_mode == 2));
                check("model_out_p", 32'(out_p), (m_mode == 2) ? 32'(m_prod) : 32'h0);
            end
        end
    end

    int acc_cyc;

    // Called at a negedge with operands to present; returns at the negedge after acceptance.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input bit keep_valid);
        bit done = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc_cyc = cyc + 1;
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) check("accept_timeout", 32'h0, 32'h1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [15:0] exp, input bit chk_lat);
        bit done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (out_valid) begin
                check(name, 32'(out_p), 32'(exp));
                if (chk_lat) check({name, "_latency"}, 32'(cyc - acc_cyc), 32'd4);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    int a1, a2, a3;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_during_rst", 32'(in_ready), 32'h0);
        check("valid_during_rst", 32'(out_valid), 32'h0);
        check("p_during_rst", 32'(out_p), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'h1);

        // zero operands, single-cycle result pulse
        accept(8'h00, 8'h00, 0);
        wait_result("zero_prod", 16'h0000, 1);
        @(negedge clk);
        check("zero_valid_pulse", 32'(out_valid), 32'h0);

        accept(8'hFF, 8'hFF, 0);
        check("ff_busy_ready", 32'(in_ready), 32'h0);
        wait_result("ff_prod", 16'hFE01, 1);

        // back-to-back stream with in_valid held high
        accept(8'h12, 8'h34, 1);
        a1 = acc_cyc;
        in_a = 8'hA5; in_b = 8'h3C;
        wait_result("b2b_0", 16'h03A8, 1);
        accept(8'hA5, 8'h3C, 1);
        a2 = acc_cyc;
        in_a = 8'h01; in_b = 8'h80;
        wait_result("b2b_1", 16'h26AC, 1);
        accept(8'h01, 8'h80, 0);
        a3 = acc_cyc;
        wait_result("b2b_2", 16'h0080, 1);
        check("b2b_gap_01", 32'(a2 - a1), 32'd6);
        check("b2b_gap_12", 32'(a3 - a2), 32'd6);
        @(negedge clk);

        // backpressure
        out_ready = 1'b0;
        accept(8'h0F, 8'hF0, 0);
        wait_result("bp_prod", 16'h0E10, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_p", 32'(out_p), 32'h0E10);
            check("bp_hold_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after", 32'(in_ready), 32'h1);

        // input toggling while busy must not disturb the product
        accept(8'h77, 8'h99, 0);
        for (int i = 0; i < 3; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_result("toggle_prod", 16'h471F, 0);
        @(negedge clk);

        // reset abort mid-operation
        accept(8'hFF, 8'hFF, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_in_rst", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'h0);
            check("abort_p_zero", 32'(out_p), 32'h0);
        end
        accept(8'h03, 8'h05, 0);
        wait_result("post_abort_prod", 16'h000F, 1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
